// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch/execute side bundle for the branch predictor
interface branch_predictor_if;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        predicted;
    logic [31:0] predicted_addr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_predicted;
    logic [31:0] upd_pred_target;
    logic        flush;
    logic [31:0] saved_addr;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output lookup_en, lookup_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_predicted, upd_pred_target,
        input  predicted, predicted_addr, flush, saved_addr, stat_branches, stat_mispredicts
    );

    modport slave (
        input  lookup_en, lookup_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_predicted, upd_pred_target,
        output predicted, predicted_addr, flush, saved_addr, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating direction counters
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bus
);
    localparam int TAG_BITS = 32 - IDX_BITS - 2;

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic        flush_q;
    logic [31:0] saved_q;
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    logic [IDX_BITS-1:0] l_idx;
    logic [TAG_BITS-1:0] l_tag;
    logic                l_hit;

    assign l_idx = bus.lookup_pc[IDX_BITS+1:2];
    assign l_tag = bus.lookup_pc[31:IDX_BITS+2];
    assign l_hit = valid_q[l_idx] & (tag_q[l_idx] == l_tag);

    // Lookup reads pre-update table contents; no bypass from the update port.
    assign bus.predicted      = bus.lookup_en & l_hit & ctr_q[l_idx][1];
    assign bus.predicted_addr = l_hit ? target_q[l_idx] : bus.lookup_pc + 32'd4;

    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;
    logic                mis;
    logic                ctr_write;
    logic [1:0]          ctr_next;

    assign u_idx = bus.upd_pc[IDX_BITS+1:2];
    assign u_tag = bus.upd_pc[31:IDX_BITS+2];
    assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

    assign mis = bus.upd_valid &
                 ((bus.upd_taken != bus.upd_predicted) |
                  (bus.upd_taken & bus.upd_predicted & (bus.upd_target != bus.upd_pred_target)));

    // A not-taken miss leaves the table alone; a taken miss allocates weakly-taken.
    assign ctr_write = bus.upd_valid & (u_hit | bus.upd_taken);

    always_comb begin
        ctr_next = ctr_q[u_idx];
        if (u_hit) begin
            if (bus.upd_taken) begin
                if (ctr_q[u_idx] != 2'b11) ctr_next = ctr_q[u_idx] + 2'b01;
            end else begin
                if (ctr_q[u_idx] != 2'b00) ctr_next = ctr_q[u_idx] - 2'b01;
            end
        end else begin
            ctr_next = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            flush_q       <= 1'b0;
            saved_q       <= 32'd0;
            branches_q    <= 32'd0;
            mispredicts_q <= 32'd0;
        end else begin
            flush_q <= mis;
            if (bus.upd_valid) begin
                saved_q    <= bus.upd_pc + 32'd4;
                branches_q <= branches_q + 32'd1;
                if (bus.upd_taken) valid_q[u_idx] <= 1'b1;
            end
            if (mis) mispredicts_q <= mispredicts_q + 32'd1;
            if (ctr_write) ctr_q[u_idx] <= ctr_next;
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (bus.upd_valid & bus.upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.upd_target;
        end
    end

    assign bus.flush            = flush_q;
    assign bus.saved_addr       = saved_q;
    assign bus.stat_branches    = branches_q;
    assign bus.stat_mispredicts = mispredicts_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed checks of branch_predictor against a table model
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predictor_if bus();

    branch_predictor #(.ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 1'b0;

    bit          m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    bit          m_flush;
    logic [31:0] m_saved;
    logic [31:0] m_branches;
    logic [31:0] m_mispredicts;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == (pc >> 6));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc, input bit en);
        return en && m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] pc);
        return m_hit(pc) ? m_target[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_flush       = 1'b0;
        m_saved       = 32'd0;
        m_branches    = 32'd0;
        m_mispredicts = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            bit mis;
            int s;
            mis = bus.upd_valid &&
                  ((bus.upd_taken != bus.upd_predicted) ||
                   (bus.upd_taken && bus.upd_predicted && bus.upd_target != bus.upd_pred_target));
            m_flush = mis;
            if (bus.upd_valid) begin
                s = slot(bus.upd_pc);
                m_saved    = bus.upd_pc + 32'd4;
                m_branches = m_branches + 32'd1;
                if (mis) m_mispredicts = m_mispredicts + 32'd1;
                if (m_hit(bus.upd_pc)) begin
                    if (bus.upd_taken) begin
                        m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_target[s] = bus.upd_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (bus.upd_taken) begin
                    m_valid[s]  = 1'b1;
                    m_tag[s]    = bus.upd_pc >> 6;
                    m_target[s] = bus.upd_target;
                    m_ctr[s]    = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("predicted",        {31'd0, bus.predicted}, {31'd0, m_pred(bus.lookup_pc, bus.lookup_en)});
            chk("predicted_addr",   bus.predicted_addr,     m_addr(bus.lookup_pc));
            chk("flush",            {31'd0, bus.flush},     {31'd0, m_flush});
            chk("saved_addr",       bus.saved_addr,         m_saved);
            chk("stat_branches",    bus.stat_branches,      m_branches);
            chk("stat_mispredicts", bus.stat_mispredicts,   m_mispredicts);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.upd_valid       = 1'b0;
        bus.upd_pc          = 32'd0;
        bus.upd_taken       = 1'b0;
        bus.upd_target      = 32'd0;
        bus.upd_predicted   = 1'b0;
        bus.upd_pred_target = 32'd0;
    endtask

    task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                       input bit pred, input logic [31:0] ptgt);
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_taken       = taken;
        bus.upd_target      = tgt;
        bus.upd_predicted   = pred;
        bus.upd_pred_target = ptgt;
    endtask

    // One update cycle followed by a lookup check of 0x100 after the edge.
    task automatic upd_then_pred(input string name, input bit taken, input bit exp_pred);
        upd(32'h100, taken, 32'h200, 1'b0, 32'h104);
        step();
        idle();
        @(negedge clk);
        chk(name, {31'd0, bus.predicted}, {31'd0, exp_pred});
        step();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tagv;
        case ($urandom % 4)
            0:       tagv = 32'd0;
            1:       tagv = 32'd1;
            2:       tagv = 32'd2;
            default: tagv = 32'h03FF_FFFF;
        endcase
        return (tagv << 6) | (($urandom % 16) << 2) | ($urandom % 4);
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.lookup_en = 1'b1;
        bus.lookup_pc = 32'h100;
        idle();
        model_reset();
        #12;
        rst_n    = 1'b1;
        check_en = 1'b1;

        @(negedge clk);
        chk("reset predicted",    {31'd0, bus.predicted}, 32'd0);
        chk("reset pred_addr",    bus.predicted_addr,     32'h104);
        chk("reset flush",        {31'd0, bus.flush},     32'd0);
        chk("reset branches",     bus.stat_branches,      32'd0);

        step();
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        step();
        idle();
        @(negedge clk);
        chk("alloc flush",        {31'd0, bus.flush},     32'd1);
        chk("alloc saved",        bus.saved_addr,         32'h104);
        chk("alloc mispredicts",  bus.stat_mispredicts,   32'd1);
        chk("alloc predicted",    {31'd0, bus.predicted}, 32'd1);
        chk("alloc pred_addr",    bus.predicted_addr,     32'h200);
        step();
        @(negedge clk);
        chk("flush one cycle",    {31'd0, bus.flush},     32'd0);
        step();

        upd_then_pred("ctr 10->01", 1'b0, 1'b0);
        upd_then_pred("ctr 01->00", 1'b0, 1'b0);
        upd_then_pred("ctr 00->01", 1'b1, 1'b0);
        upd_then_pred("ctr 01->10", 1'b1, 1'b1);
        upd_then_pred("ctr 10->11", 1'b1, 1'b1);
        upd_then_pred("ctr 11 sat", 1'b1, 1'b1);
        upd_then_pred("ctr 11->10", 1'b0, 1'b1);

        upd(32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
        step();
        idle();
        bus.lookup_pc = 32'h100;
        @(negedge clk);
        chk("alias predicted",    {31'd0, bus.predicted}, 32'd0);
        chk("alias pred_addr",    bus.predicted_addr,     32'h104);
        step();

        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        step();
        upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        @(negedge clk);
        chk("no bypass addr",     bus.predicted_addr,     32'h200);
        step();
        idle();
        @(negedge clk);
        chk("target mis flush",   {31'd0, bus.flush},     32'd1);
        chk("target rewritten",   bus.predicted_addr,     32'h300);

        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async flush",        {31'd0, bus.flush},     32'd0);
        chk("async branches",     bus.stat_branches,      32'd0);
        chk("async mispredicts",  bus.stat_mispredicts,   32'd0);
        chk("async pred_addr",    bus.predicted_addr,     32'h104);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset miss",    bus.predicted_addr,     32'h104);

        for (int c = 0; c < 3000; c++) begin
            step();
            bus.lookup_en = ($urandom % 4) != 0;
            bus.lookup_pc = ($urandom % 3 == 0) ? bus.upd_pc : rand_pc();
            if ($urandom % 3 != 0) begin
                logic [31:0] pc;
                logic [31:0] tgt;
                bit          pred;
                logic [31:0] ptgt;
                pc   = rand_pc();
                tgt  = ($urandom % 2) ? m_addr(pc) : {$urandom} & 32'hFFFF_FFFC;
                pred = ($urandom % 4 != 0) ? m_pred(pc, 1'b1) : bit'($urandom % 2);
                ptgt = ($urandom % 4 != 0) ? m_addr(pc) : tgt;
                upd(pc, bit'($urandom % 2), tgt, pred, ptgt);
            end else begin
                idle();
            end
        end
        step();
        idle();
        @(negedge clk);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Branch target buffer with 2-bit saturating direction counters. It sits directly upstream of the instruction-fetch stage and drives that stage's predicted, predicted_addr, flush and saved_addr inputs. Each cycle it looks up the current fetch PC. It is trained by resolved branches returned from execute. It detects mispredictions and supplies the fall-through recovery address.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of two, 2..256
IDX_BITS, $clog2(ENTRIES), index width; derived, do not override

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
lookup_en  in  1  fetch advancing this cycle (fetch-stage PC load enable)
lookup_pc  in  32  current fetch PC (fetch-stage pc_out)
predicted  out  1  predict taken for lookup_pc
predicted_addr  out  32  predicted target for lookup_pc
upd_valid  in  1  a conditional branch resolved in execute this cycle
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual branch outcome
upd_target  in  32  actual branch target
upd_predicted  in  1  predicted value that was issued with this branch
upd_pred_target  in  32  predicted_addr that was issued with this branch
flush  out  1  misprediction pulse to the fetch stage
saved_addr  out  32  recovery fall-through address (upd_pc+4)
stat_branches  out  32  resolved-branch count
stat_mispredicts  out  32  misprediction count

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Entry contents: valid bit, tag = pc[31:IDX_BITS+2], target[31:0], ctr[1:0].
- Indexing: idx = pc[IDX_BITS+1:2]. pc[1:0] is ignored.
- Reset state: all valid bits = 0; all ctr = 2'b01 (weakly not-taken). flush = 0, saved_addr = 0, both stat counters = 0. Targets and tags need no reset.
- Lookup: purely combinational from lookup_pc, with no added latency.
  - hit = valid[idx] & (tag[idx] == lookup_pc tag).
  - predicted = lookup_en & hit & ctr[idx][1].
  - predicted_addr = target[idx] when hit, else lookup_pc+4.
- Update: all writes happen on the rising clk edge when upd_valid = 1.
- Update on an entry hit (tag of upd_pc matches):
  - taken: ctr increments, saturating at 11, and target is rewritten with upd_target.
  - not taken: ctr decrements, saturating at 00, and target is unchanged.
- Update on a miss, taken: allocate the entry, overwriting any previous occupant. valid = 1, tag written, target = upd_target, ctr = 2'b10.
- Update on a miss, not taken: no table change.
- Misprediction condition: mis = upd_valid & ((upd_taken != upd_predicted) | (upd_taken & upd_predicted & (upd_target != upd_pred_target))).
- flush: registered and high for exactly one cycle after the edge on which mis = 1. Back-to-back mispredicts give consecutive flush cycles.
- saved_addr: registered with upd_pc+4 (32-bit wrap) on every upd_valid edge. It holds its value otherwise.
- stat_branches: +1 on every upd_valid edge.
- stat_mispredicts: +1 on every mis edge.
- Both stat counters wrap modulo 2^32.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. No bypass.
- Reset asserted mid-operation: all state clears immediately, without waiting for clk. A pending flush is dropped.
- Lookup with lookup_en = 0: predicted = 0. predicted_addr is still driven.

Test Plan:
- Reset, then lookup_pc = 0x100, lookup_en = 1 -> predicted = 0, predicted_addr = 0x104; flush = 0, stats = 0.
- Update at upd_pc = 0x100: taken, target 0x200, upd_predicted = 0 -> next cycle flush = 1 for 1 cycle, saved_addr = 0x104, stat_mispredicts = 1. A following lookup at 0x100 gives predicted = 1, predicted_addr = 0x200.
- Two not-taken updates at 0x100 (ctr 10 -> 01 -> 00), then three taken updates -> predicted = 0 until the second taken (ctr 10), stays 1 at ctr 11. Further taken updates leave ctr at 11 (saturation).
- Aliasing (ENTRIES = 16): a taken update at 0x140 evicts 0x100 (same idx 0) -> lookup at 0x100 gives predicted = 0, predicted_addr = 0x104.
- Taken, predicted, with upd_pred_target = 0x200 and upd_target = 0x300 -> flush pulse; entry target becomes 0x300. Same-cycle lookup of that PC still returns 0x200.
- rst_n pulled low asynchronously between edges while flush = 1 -> flush, stats and valid bits are 0 immediately. After release, the first lookup misses.
